quad_step_decoder: RTL and testbench
====================================

Name: quad_step_decoder

Overview:
- Front-end stage for the 3-bit up/down counter.
- Converts raw quadrature encoder inputs into a one-cycle step pulse and a direction level. The counter stage consumes them as a count-enable and its up_down select, with up_down=1 meaning increment.
- Contains per-input synchronisation, a glitch filter, an init/run state machine, x4 Gray-code decoding and sticky illegal-transition detection.

Parameters:
- FILTER_CYCLES, default 3: consecutive cycles a synchronised input must differ from its filtered value before the filtered value updates. Legal range 1..15.

Ports:
- clk  input  1: rising-edge clock.
- reset  input  1: asynchronous, active-low reset.
- enc_a  input  1: encoder phase A, asynchronous to clk.
- enc_b  input  1: encoder phase B, asynchronous to clk.
- err_clr  input  1: synchronous clear of err.
- step  output  1: one-cycle pulse per legal encoder edge.
- up_down  output  1: direction of the last legal step (1=up, 0=down).
- err  output  1: sticky flag for an illegal transition.

Behaviour:
- Reset (reset=0, asynchronous) clears everything:
  - step=0, up_down=1, err=0.
  - sync flops, filtered values and prev register = 0.
  - filter counters = 0.
  - FSM = INIT; INIT counter = 0.
- Synchroniser: 2 flops per input (sync1, sync2).
- Filter, per input:
  - If sync2 != filt, the counter increments. When the counter reaches FILTER_CYCLES, filt <= sync2 and the counter returns to 0.
  - If sync2 == filt, the counter = 0.
  - Any pulse shorter than FILTER_CYCLES cycles at sync2 is discarded.
- FSM state INIT (entered from reset):
  - Lasts exactly 3 cycles after reset deasserts.
  - filt <= sync2 directly each cycle (filter bypassed, counters held at 0); prev <= filt.
  - No step, no err.
  - Goes to RUN after the 3rd cycle.
- FSM state RUN:
  - Filter active.
  - Decoder compares cur={filt_a,filt_b} against prev every cycle, then prev <= cur.
- Decode table:
  - Up sequence: 00->10->11->01->00 (A leads B).
  - Down sequence: 00->01->11->10->00.
  - Legal up/down change: step <= 1 for one cycle; up_down <= 1 or 0 in the same edge.
  - No change: step <= 0; up_down holds.
  - Both bits changed (00<->11, 10<->01): step <= 0, up_down holds, err <= 1.
- err:
  - Sticky until err_clr=1, which clears it at the next edge.
  - If err_clr and an illegal transition occur in the same cycle, set wins and err stays 1.
- Latency: let edge k be the first clk edge at which sync1 captures a new level.
  - sync2 updates at edge k+1.
  - filt updates at edge k+1+FILTER_CYCLES.
  - step is high for exactly the cycle following edge k+2+FILTER_CYCLES.
- Step rate: each legal transition produces exactly one step pulse. Back-to-back steps on consecutive cycles are legal only if the filtered phases change that fast; no merging, no dropping.
- A and B filtered on the same edge: treated as a simultaneous change and decoded against prev (a 2-bit change is illegal).
- Reset mid-operation: an active step pulse drops immediately; the block re-enters INIT on reset release. No step is generated for the encoder's current position.
- Direction reversal mid-sequence (e.g. 00->10->00) gives one up step then one down step.

Test Plan:
- Reset behaviour (FILTER_CYCLES=3):
  - Stimulus: enc_a=enc_b=1 held through reset and release.
  - Required: step=0, err=0, up_down=1 throughout reset and through INIT; no step after RUN is entered with inputs stable.
- Forward rotation:
  - Stimulus: from 00, drive 10,11,01,00 with each phase held 10 cycles.
  - Required: exactly 4 single-cycle step pulses; up_down=1. First pulse is in the cycle after edge k+5 (k = first edge at which sync1 captures the change).
- Reverse rotation:
  - Stimulus: from 00, drive 01,11,10,00.
  - Required: 4 steps; up_down=0 from the first step onward. Then a single forward edge gives 1 step with up_down=1.
- Glitch rejection:
  - Stimulus: enc_a high for 2 clk cycles, then low; FILTER_CYCLES=3.
  - Required: no step, err=0, filtered A unchanged. Repeating with a 4-cycle pulse gives step up then step down.
- Illegal transition and clear:
  - Stimulus: from 00, switch both inputs to 11 on the same edge.
  - Required: err=1, no step, up_down unchanged.
  - Then assert err_clr in the same cycle as another 11->00 illegal jump: err stays 1.
  - Then err_clr alone: err=0 at the next edge.
- Reset mid-step:
  - Stimulus: assert reset during the cycle step=1.
  - Required: step=0 immediately (asynchronous), up_down=1, err=0; after release, 3 INIT cycles with no step.

Source files
------------

// File: rtl/quad_step_decoder.sv
// Purpose: quadrature encoder front end: sync, glitch filter, x4 Gray decode, sticky illegal-edge flag.
// Latency: step pulses in the cycle after edge k+2+FILTER_CYCLES (k = edge where sync1 captures a change).
// Backpressure: none; step is a single-cycle pulse, up_down a level, err sticky until err_clr.
module quad_step_decoder #(
    parameter int unsigned FILTER_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    input  logic err_clr,
    output logic step,
    output logic up_down,
    output logic err
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // Counter value at which the next differing sample commits the filtered level.
    localparam logic [3:0] FILT_LAST = 4'(FILTER_CYCLES - 1);

    // Bit 1 carries phase A, bit 0 carries phase B throughout.
    state_e          state_q;
    logic [1:0]      init_cnt_q;
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      filt_q;
    logic [1:0]      filt_d;
    logic [1:0][3:0] cnt_q;
    logic [1:0][3:0] cnt_d;
    logic [1:0]      prev_q;
    logic            step_q;
    logic            up_down_q;
    logic            err_q;
    logic            mv_up;
    logic            mv_dn;
    logic            mv_bad;

    // Per-phase glitch filter; bypassed during INIT so the filter starts at the encoder's resting level.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (state_q == ST_INIT) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == FILT_LAST) begin
                    filt_d[i] = sync2_q[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Gray-code transition classification of the last filtered pair against the current one.
    always_comb begin
        mv_up  = 1'b0;
        mv_dn  = 1'b0;
        mv_bad = 1'b0;
        case ({prev_q, filt_q})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: mv_up  = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: mv_dn  = 1'b1;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: mv_bad = 1'b1;
            default: ;
        endcase
    end

    // Synchronisers, filter state, INIT/RUN sequencing and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            filt_q     <= '0;
            cnt_q      <= '0;
            prev_q     <= '0;
            step_q     <= 1'b0;
            up_down_q  <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            sync1_q <= {enc_a, enc_b};
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            case (state_q)
                ST_INIT: begin
                    // prev follows the value being loaded into filt so the first RUN
                    // comparison sees the resting position as "no change".
                    prev_q <= sync2_q;
                    step_q <= 1'b0;
                    if (init_cnt_q == 2'd2) begin
                        state_q <= ST_RUN;
                    end else begin
                        init_cnt_q <= init_cnt_q + 2'd1;
                    end
                end
                ST_RUN: begin
                    prev_q <= filt_q;
                    step_q <= mv_up | mv_dn;
                    if (mv_up) begin
                        up_down_q <= 1'b1;
                    end else if (mv_dn) begin
                        up_down_q <= 1'b0;
                    end
                    // A fresh illegal transition wins over a simultaneous clear.
                    if (mv_bad) begin
                        err_q <= 1'b1;
                    end else if (err_clr) begin
                        err_q <= 1'b0;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign step    = step_q;
    assign up_down = up_down_q;
    assign err     = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios plus randomized encoder traffic,
// checked cycle by cycle against a history-window reference model.
module tb_quad_step_decoder;

    localparam int F = 3;

    logic clk = 1'b0;
    logic reset;
    logic enc_a;
    logic enc_b;
    logic err_clr;
    logic step;
    logic up_down;
    logic err;

    int n_vec = 0;
    int n_bad = 0;

    quad_step_decoder #(.FILTER_CYCLES(F)) dut (
        .clk     (clk),
        .reset   (reset),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .err_clr (err_clr),
        .step    (step),
        .up_down (up_down),
        .err     (err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Raw input levels indexed by clock edge since reset release.
    bit         ha[$];
    bit         hb[$];
    logic [1:0] m_filt;
    logic [1:0] m_prev;
    logic       e_step;
    logic       e_ud;
    logic       e_err;
    logic [1:0] ORD [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    function automatic int pos_of(input logic [1:0] v);
        for (int i = 0; i < 4; i++) if (ORD[i] == v) return i;
        return 0;
    endfunction

    // True when the last F RUN-visible synchronised samples all differ from fv.
    function automatic bit settled_other(input int which, input int n, input logic fv);
        bit s;
        if (n - 1 - F < 1) return 1'b0;
        for (int i = n - 1 - F; i <= n - 2; i++) begin
            s = (which == 0) ? ha[i] : hb[i];
            if (s == fv) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        ha.delete();
        hb.delete();
        m_filt = 2'b00;
        m_prev = 2'b00;
        e_step = 1'b0;
        e_ud   = 1'b1;
        e_err  = 1'b0;
    endtask

    task automatic model_edge(input logic a, input logic b, input logic clr);
        int n;
        int d;
        logic [1:0] nf;
        ha.push_back(a);
        hb.push_back(b);
        n = ha.size() - 1;
        if (n < 3) begin
            e_step = 1'b0;
            e_err  = 1'b0;
            if (n == 2) begin
                m_filt = {ha[0], hb[0]};
                m_prev = m_filt;
            end
        end else begin
            nf = m_filt;
            if (settled_other(0, n, m_filt[1])) nf[1] = ~m_filt[1];
            if (settled_other(1, n, m_filt[0])) nf[0] = ~m_filt[0];
            d = (pos_of(m_filt) - pos_of(m_prev) + 4) % 4;
            e_step = (d == 1) || (d == 3);
            if (d == 1) e_ud = 1'b1;
            if (d == 3) e_ud = 1'b0;
            if (d == 2) e_err = 1'b1;
            else if (clr) e_err = 1'b0;
            m_prev = m_filt;
            m_filt = nf;
        end
    endtask

    // Entered at a negedge; drives one cycle of inputs and returns at the next negedge.
    task automatic cyc(input logic a, input logic b, input logic clr);
        enc_a   = a;
        enc_b   = b;
        err_clr = clr;
        @(posedge clk);
        model_edge(a, b, clr);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic a, input logic b);
        reset   = 1'b0;
        enc_a   = a;
        enc_b   = b;
        err_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic settle();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int steps = 0;
        reset = 1'b0; enc_a = 1'b1; enc_b = 1'b1; err_clr = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({step, up_down, err} !== 3'b010) begin
                n_bad++;
                $display("FAIL reset_hold c%0d: step/ud/err=%b%b%b want 010", i, step, up_down, err);
            end
        end
        reset = 1'b1;
        for (int c = 0; c < 15; c++) begin
            cyc(1'b1, 1'b1, 1'b0);
            n_vec++;
            if ({step, up_down, err} !== {e_step, e_ud, e_err}) begin
                n_bad++;
                $display("FAIL reset_run c%0d: step/ud/err=%b%b%b want %b%b%b", c, step, up_down, err, e_step, e_ud, e_err);
            end
            if (step) steps++;
        end
        n_vec++;
        if (steps !== 0) begin
            n_bad++;
            $display("FAIL reset_nostep: steps=%0d want 0", steps);
        end
    endtask

    task automatic test_forward();
        logic [1:0] seq [4];
        int steps = 0, first = -1, c = 0;
        seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        do_reset(1'b0, 1'b0);
        settle();
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 10; j++) begin
                cyc(seq[p][1], seq[p][0], 1'b0);
                n_vec++;
                if ({step, up_down, err} !== {e_step, e_ud, e_err}) begin
                    n_bad++;
                    $display("FAIL fwd c%0d: step/ud/err=%b%b%b want %b%b%b", c, step, up_down, err, e_step, e_ud, e_err);
                end
                if (step) begin
                    steps++;
                    if (first < 0) first = c;
                end
                c++;
            end
        end
        n_vec++;
        if (steps !== 4 || first !== 5 || up_down !== 1'b1) begin
            n_bad++;
            $display("FAIL fwd_count: steps=%0d first=%0d ud=%b want 4 5 1", steps, first, up_down);
        end
    endtask

    task automatic test_reverse();
        logic [1:0] seq [5];
        int steps = 0, c = 0;
        logic ud_after_first = 1'bx;
        seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b10};
        do_reset(1'b0, 1'b0);
        settle();
        for (int p = 0; p < 5; p++) begin
            for (int j = 0; j < 10; j++) begin
                cyc(seq[p][1], seq[p][0], 1'b0);
                n_vec++;
                if ({step, up_down, err} !== {e_step, e_ud, e_err}) begin
                    n_bad++;
                    $display("FAIL rev c%0d: step/ud/err=%b%b%b want %b%b%b", c, step, up_down, err, e_step, e_ud, e_err);
                end
                if (step) begin
                    steps++;
                    if (steps == 1) ud_after_first = up_down;
                end
                c++;
            end
            if (p == 3) begin
                n_vec++;
                if (steps !== 4 || ud_after_first !== 1'b0 || up_down !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rev_count: steps=%0d ud1=%b ud=%b want 4 0 0", steps, ud_after_first, up_down);
                end
            end
        end
        n_vec++;
        if (steps !== 5 || up_down !== 1'b1) begin
            n_bad++;
            $display("FAIL rev_fwd_edge: steps=%0d ud=%b want 5 1", steps, up_down);
        end
    endtask

    task automatic test_glitch();
        int ups = 0, dns = 0, c = 0, len;
        do_reset(1'b0, 1'b0);
        settle();
        for (int r = 0; r < 2; r++) begin
            len = (r == 0) ? 2 : 4;
            for (int j = 0; j < len + 12; j++) begin
                cyc(j < len, 1'b0, 1'b0);
                n_vec++;
                if ({step, up_down, err} !== {e_step, e_ud, e_err}) begin
                    n_bad++;
                    $display("FAIL glitch c%0d: step/ud/err=%b%b%b want %b%b%b", c, step, up_down, err, e_step, e_ud, e_err);
                end
                if (step && up_down) ups++;
                if (step && !up_down) dns++;
                c++;
            end
            n_vec++;
            if (ups !== r || dns !== r || err !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch_len%0d: ups=%0d dns=%0d err=%b want %0d %0d 0", len, ups, dns, err, r, r);
            end
        end
    endtask

    task automatic test_illegal();
        int steps = 0;
        do_reset(1'b0, 1'b0);
        settle();
        for (int j = 0; j < 10; j++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (step) steps++;
        end
        n_vec++;
        if (err !== 1'b1 || steps !== 0 || up_down !== 1'b1 || e_err !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_set: err=%b steps=%0d ud=%b want 1 0 1", err, steps, up_down);
        end
        // Clear lands on the same edge as the 11->00 detection (edge k+5).
        for (int j = 0; j < 10; j++) begin
            cyc(1'b0, 1'b0, j == 5);
            n_vec++;
            if ({step, up_down, err} !== {e_step, e_ud, e_err}) begin
                n_bad++;
                $display("FAIL illegal_clr_race c%0d: step/ud/err=%b%b%b want %b%b%b", j, step, up_down, err, e_step, e_ud, e_err);
            end
        end
        n_vec++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_set_wins: err=%b want 1", err);
        end
        cyc(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_clear: err=%b want 0", err);
        end
    endtask

    task automatic test_back_to_back();
        int steps = 0, s0 = -1, s1 = -1;
        do_reset(1'b0, 1'b0);
        settle();
        for (int c = 0; c < 14; c++) begin
            cyc(1'b1, c > 0, 1'b0);
            n_vec++;
            if ({step, up_down, err} !== {e_step, e_ud, e_err}) begin
                n_bad++;
                $display("FAIL b2b c%0d: step/ud/err=%b%b%b want %b%b%b", c, step, up_down, err, e_step, e_ud, e_err);
            end
            if (step) begin
                if (steps == 0) s0 = c; else s1 = c;
                steps++;
            end
        end
        n_vec++;
        if (steps !== 2 || s0 !== 5 || s1 !== 6) begin
            n_bad++;
            $display("FAIL b2b_timing: steps=%0d at %0d,%0d want 2 at 5,6", steps, s0, s1);
        end
    endtask

    task automatic test_reset_mid_step();
        int c = 0, steps = 0;
        do_reset(1'b0, 1'b0);
        settle();
        while (c < 12 && step !== 1'b1) begin
            cyc(1'b0, 1'b1, 1'b0);
            c++;
        end
        n_vec++;
        if (step !== 1'b1 || up_down !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_pre: step=%b ud=%b want 1 0 within 12 cycles", step, up_down);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({step, up_down, err} !== 3'b010) begin
            n_bad++;
            $display("FAIL midrst_async: step/ud/err=%b%b%b want 010", step, up_down, err);
        end
        @(negedge clk);
        do_reset(1'b0, 1'b1);
        for (int j = 0; j < 10; j++) begin
            cyc(1'b0, 1'b1, 1'b0);
            n_vec++;
            if ({step, up_down, err} !== {e_step, e_ud, e_err}) begin
                n_bad++;
                $display("FAIL midrst_init c%0d: step/ud/err=%b%b%b want %b%b%b", j, step, up_down, err, e_step, e_ud, e_err);
            end
            if (step) steps++;
        end
        n_vec++;
        if (steps !== 0) begin
            n_bad++;
            $display("FAIL midrst_nostep: steps=%0d want 0", steps);
        end
    endtask

    task automatic test_random();
        int p = 0, c = 0, r, len;
        logic [1:0] v;
        do_reset(1'b0, 1'b0);
        settle();
        while (c < 1500) begin
            r = $urandom_range(0, 9);
            if (r < 4) p = (p + 1) % 4;
            else if (r < 8) p = (p + 3) % 4;
            else if (r == 8) p = (p + 2) % 4;
            v = ORD[p];
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                cyc(v[1], v[0], $urandom_range(0, 9) == 0);
                n_vec++;
                if ({step, up_down, err} !== {e_step, e_ud, e_err}) begin
                    n_bad++;
                    $display("FAIL rand c%0d: step/ud/err=%b%b%b want %b%b%b", c, step, up_down, err, e_step, e_ud, e_err);
                end
                c++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_illegal();
        test_back_to_back();
        test_reset_mid_step();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
